// File: rtl/irq_pkg.sv
// Shared FSM type and config register map for ext_irq_controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } irq_state_t;

  localparam logic [1:0] IRQ_ADDR_MASK = 2'd0;
  localparam logic [1:0] IRQ_ADDR_MODE = 2'd1;
  localparam logic [1:0] IRQ_ADDR_PEND = 2'd2;

endpackage

// File: rtl/irq_sync.sv
// Per-channel input synchroniser with an optional registered rising-edge pulse.
// The edge detector is only built when EXT_IRQ_EDGE_EN is defined.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

`ifdef EXT_IRQ_EDGE_EN
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_o;
    end
  end

  assign rise_o = sync_o & ~prev_q;
`else
  assign rise_o = 1'b0;
`endif

endmodule

// File: rtl/ext_irq_controller.sv
// NIRQ-channel interrupt controller feeding the core's single ExtIRQ line.
// Define EXT_IRQ_EDGE_EN to build the MODE register and per-channel edge capture.
module ext_irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N           = 64,
  parameter int unsigned NIRQ        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [N-1:0]    cfg_wdata,
  output logic [N-1:0]    cfg_rdata,
  input  logic            irq_ack,
  input  logic            irq_eoi,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic            irq_active
);

  logic [NIRQ-1:0] sync, rise;
  logic [NIRQ-1:0] mask_q, pend_q, pend_d, cand, mode_rd;
  irq_state_t      state_q, state_d;
  logic [IDW-1:0]  id_q, id_d, winner;
  logic            ext_irq_q, active_q;
  logic            unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  for (genvar i = 0; i < NIRQ; i++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (CLOCK_50),
      .rst_ni(reset),
      .irq_i (irq_in[i]),
      .sync_o(sync[i]),
      .rise_o(rise[i])
    );
  end

`ifdef EXT_IRQ_EDGE_EN
  logic [NIRQ-1:0] mode_q, clr;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mode_q <= '0;
    end else if (cfg_we && cfg_addr == IRQ_ADDR_MODE) begin
      mode_q <= cfg_wdata[NIRQ-1:0];
    end
  end

  // Edge bits hold until W1C or ack of the presented channel; a same-edge set wins.
  always_comb begin
    clr    = '0;
    pend_d = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr[i] = (cfg_we && cfg_addr == IRQ_ADDR_PEND && cfg_wdata[i]) ||
               (irq_ack && state_q == ASSERT && id_q == IDW'(i));
      pend_d[i] = mode_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i]) : sync[i];
    end
  end

  assign mode_rd = mode_q;
`else
  logic unused_rise;

  assign unused_rise = ^rise;
  assign pend_d      = sync;
  assign mode_rd     = '0;
`endif

  assign cand = pend_q & mask_q;

  // Lowest index wins.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = ASSERT;
          id_d    = winner;
        end
      end
      ASSERT: begin
        if (irq_ack) begin
          state_d = SERVICE;
        end else if (!cand[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      ext_irq_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pend_q    <= pend_d;
      ext_irq_q <= (state_d == ASSERT);
      active_q  <= (state_d == SERVICE);
      if (cfg_we && cfg_addr == IRQ_ADDR_MASK) begin
        mask_q <= cfg_wdata[NIRQ-1:0];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      IRQ_ADDR_MASK: cfg_rdata[NIRQ-1:0] = mask_q;
      IRQ_ADDR_MODE: cfg_rdata[NIRQ-1:0] = mode_rd;
      IRQ_ADDR_PEND: cfg_rdata[NIRQ-1:0] = pend_q;
      default:       cfg_rdata = '0;
    endcase
  end

  assign ExtIRQ     = ext_irq_q;
  assign irq_id     = id_q;
  assign irq_active = active_q;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Self-checking bench for ext_irq_controller: directed scenarios plus randomized
// traffic against a queue-based behavioural model. Edge tests need EXT_IRQ_EDGE_EN.
module tb_ext_irq_controller;

  localparam int unsigned N    = 64;
  localparam int unsigned NIRQ = 4;
  localparam int unsigned IDW  = 2;
`ifdef EXT_IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic            CLOCK_50 = 1'b0;
  logic            reset = 1'b0;
  logic [NIRQ-1:0] irq_in = '0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_addr = 2'd0;
  logic [N-1:0]    cfg_wdata = '0;
  logic [N-1:0]    cfg_rdata;
  logic            irq_ack = 1'b0;
  logic            irq_eoi = 1'b0;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic            irq_active;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ext_irq_controller #(
    .N          (N),
    .NIRQ       (NIRQ),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi),
    .ExtIRQ    (ExtIRQ),
    .irq_id    (irq_id),
    .irq_active(irq_active)
  );

  // Model: pending levels lag irq_in by two edges; state 0 idle, 1 presenting, 2 in service.
  logic [NIRQ-1:0] m_mask, m_mode, m_pend, m_prev;
  logic [NIRQ-1:0] m_pipe[$];
  int              m_state;
  int              m_id;

  task automatic model_reset();
    m_mask  = '0;
    m_mode  = '0;
    m_pend  = '0;
    m_prev  = '0;
    m_pipe  = {NIRQ'(0), NIRQ'(0)};
    m_state = 0;
    m_id    = 0;
  endtask

  task automatic model_step();
    logic [NIRQ-1:0] cand, cur, rise, clr;
    cand = m_pend & m_mask;
    cur  = m_pipe.pop_front();
    m_pipe.push_back(irq_in);
    rise   = cur & ~m_prev;
    m_prev = cur;
    clr    = '0;
    if (m_state == 1 && irq_ack) clr[m_id] = 1'b1;
    if (cfg_we && cfg_addr == 2'd2) clr = clr | cfg_wdata[NIRQ-1:0];
    for (int i = 0; i < NIRQ; i++) begin
      if (EDGE && m_mode[i]) m_pend[i] = (m_pend[i] & ~clr[i]) | rise[i];
      else m_pend[i] = cur[i];
    end
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[NIRQ-1:0];
    if (EDGE && cfg_we && cfg_addr == 2'd1) m_mode = cfg_wdata[NIRQ-1:0];
    case (m_state)
      0: if (cand != '0) begin
        m_state = 1;
        for (int i = NIRQ - 1; i >= 0; i--) if (cand[i]) m_id = i;
      end
      1: if (irq_ack) m_state = 2;
         else if (!cand[m_id]) m_state = 0;
      default: if (irq_eoi) m_state = 0;
    endcase
  endtask

  function automatic logic [N-1:0] exp_rdata(input logic [1:0] addr);
    logic [N-1:0] r;
    r = '0;
    case (addr)
      2'd0: r[NIRQ-1:0] = m_mask;
      2'd1: r[NIRQ-1:0] = m_mode;
      2'd2: r[NIRQ-1:0] = m_pend;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance one rising edge, keep the model in step, then settle 1 time unit.
  task automatic tick();
    @(posedge CLOCK_50);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [N-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic do_reset();
    irq_in  = '0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    cfg_we  = 1'b0;
    reset   = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    irq_in = 4'b1111;
    model_reset();
    tick();
    tick();
    tick();
    tests++;
    if (ExtIRQ !== 1'b0) begin fails++; $display("FAIL reset_extirq: got %b want 0", ExtIRQ); end
    tests++;
    if (irq_id !== '0) begin fails++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    tests++;
    if (irq_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", irq_active); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      tests++;
      if (cfg_rdata !== '0) begin
        fails++;
        $display("FAIL reset_rdata[%0d]: got %0h want 0", a, cfg_rdata);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++;
      if (ExtIRQ !== 1'b0) begin fails++; $display("FAIL reset_masked c%0d: got %b want 0", c, ExtIRQ); end
    end
    irq_in = '0;
  endtask

  task automatic test_level_priority();
    do_reset();
    cfg_write(2'd0, 64'hF);
    irq_in = 4'b1010;
    tick();
    tick();
    tick();
    tests++;
    if (ExtIRQ !== 1'b0) begin fails++; $display("FAIL lvl_early: got %b want 0", ExtIRQ); end
    tick();
    tests++;
    if (ExtIRQ !== 1'b1) begin fails++; $display("FAIL lvl_assert: got %b want 1", ExtIRQ); end
    tests++;
    if (irq_id !== 2'd1) begin fails++; $display("FAIL lvl_id: got %0d want 1", irq_id); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tests++;
    if (irq_active !== 1'b1 || ExtIRQ !== 1'b0) begin
      fails++;
      $display("FAIL lvl_ack: got active=%b irq=%b want 1/0", irq_active, ExtIRQ);
    end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tests++;
    if (ExtIRQ !== 1'b0 || irq_active !== 1'b0) begin
      fails++;
      $display("FAIL lvl_eoi_gap: got irq=%b active=%b want 0/0", ExtIRQ, irq_active);
    end
    tick();
    tests++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
      fails++;
      $display("FAIL lvl_reassert: got irq=%b id=%0d want 1/1", ExtIRQ, irq_id);
    end
  endtask

  task automatic test_withdrawal();
    do_reset();
    cfg_write(2'd0, 64'hF);
    irq_in = 4'b0100;
    repeat (4) tick();
    tests++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin
      fails++;
      $display("FAIL wd_assert: got irq=%b id=%0d want 1/2", ExtIRQ, irq_id);
    end
    irq_in = '0;
    repeat (3) tick();
    tests++;
    if (ExtIRQ !== 1'b1) begin fails++; $display("FAIL wd_hold: got %b want 1", ExtIRQ); end
    tick();
    tests++;
    if (ExtIRQ !== 1'b0) begin fails++; $display("FAIL wd_drop: got %b want 0", ExtIRQ); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tests++;
    if (irq_active !== 1'b0 || ExtIRQ !== 1'b0) begin
      fails++;
      $display("FAIL wd_late_ack: got active=%b irq=%b want 0/0", irq_active, ExtIRQ);
    end
  endtask

`ifdef EXT_IRQ_EDGE_EN
  task automatic test_edge_capture();
    do_reset();
    cfg_write(2'd1, 64'h1);
    cfg_write(2'd0, 64'h1);
    cfg_addr = 2'd2;
    irq_in   = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    tick();
    tests++;
    if (cfg_rdata !== 64'h1) begin fails++; $display("FAIL edge_pend_set: got %0h want 1", cfg_rdata); end
    tick();
    tests++;
    if (ExtIRQ !== 1'b1 || cfg_rdata !== 64'h1) begin
      fails++;
      $display("FAIL edge_held: got irq=%b pend=%0h want 1/1", ExtIRQ, cfg_rdata);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tests++;
    if (cfg_rdata !== 64'h0 || irq_active !== 1'b1) begin
      fails++;
      $display("FAIL edge_ack_clr: got pend=%0h active=%b want 0/1", cfg_rdata, irq_active);
    end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    tests++;
    if (ExtIRQ !== 1'b0 || irq_active !== 1'b0) begin
      fails++;
      $display("FAIL edge_eoi_quiet: got irq=%b active=%b want 0/0", ExtIRQ, irq_active);
    end
  endtask

  task automatic test_edge_collision();
    do_reset();
    cfg_write(2'd1, 64'h1);
    cfg_write(2'd0, 64'h1);
    cfg_addr = 2'd2;
    irq_in   = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    tests++;
    if (ExtIRQ !== 1'b1) begin fails++; $display("FAIL coll_assert: got %b want 1", ExtIRQ); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tests++;
    if (cfg_rdata !== 64'h1 || irq_active !== 1'b1) begin
      fails++;
      $display("FAIL coll_set_wins: got pend=%0h active=%b want 1/1", cfg_rdata, irq_active);
    end
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tests++;
    if (ExtIRQ !== 1'b0) begin fails++; $display("FAIL coll_gap: got %b want 0", ExtIRQ); end
    tick();
    tests++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin
      fails++;
      $display("FAIL coll_reassert: got irq=%b id=%0d want 1/0", ExtIRQ, irq_id);
    end
  endtask
`endif

  task automatic test_reset_mid_service();
    do_reset();
    cfg_write(2'd0, 64'hF);
    irq_in = 4'b1000;
    repeat (4) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack  = 1'b0;
    cfg_addr = 2'd2;
    #1;
    tests++;
    if (irq_active !== 1'b1 || cfg_rdata !== 64'h8) begin
      fails++;
      $display("FAIL rms_pre: got active=%b pend=%0h want 1/8", irq_active, cfg_rdata);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (irq_active !== 1'b0 || ExtIRQ !== 1'b0 || cfg_rdata !== '0) begin
      fails++;
      $display("FAIL rms_async: got active=%b irq=%b pend=%0h want 0/0/0",
               irq_active, ExtIRQ, cfg_rdata);
    end
    model_reset();
    irq_in = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) irq_in = NIRQ'($urandom);
      cfg_we    = ($urandom_range(7) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = {$urandom, $urandom};
      irq_ack   = ($urandom_range(2) == 0);
      irq_eoi   = ($urandom_range(3) == 0);
      tick();
      tests++;
      if (ExtIRQ !== (m_state == 1)) begin
        fails++;
        $display("FAIL rnd_extirq c%0d: got %b want %b", c, ExtIRQ, m_state == 1);
      end
      tests++;
      if (irq_active !== (m_state == 2)) begin
        fails++;
        $display("FAIL rnd_active c%0d: got %b want %b", c, irq_active, m_state == 2);
      end
      tests++;
      if (irq_id !== IDW'(m_id)) begin
        fails++;
        $display("FAIL rnd_id c%0d: got %0d want %0d", c, irq_id, m_id);
      end
      tests++;
      if (cfg_rdata !== exp_rdata(cfg_addr)) begin
        fails++;
        $display("FAIL rnd_rdata c%0d a%0d: got %0h want %0h", c, cfg_addr, cfg_rdata,
                 exp_rdata(cfg_addr));
      end
    end
    cfg_we  = 1'b0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_level_priority();
    test_withdrawal();
`ifdef EXT_IRQ_EDGE_EN
    test_edge_capture();
    test_edge_collision();
`endif
    test_reset_mid_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_irq_controller.md
# ext_irq_controller

Parametrised external-interrupt controller that sits between off-chip/peripheral interrupt lines and the `processor_arm` core's single `ExtIRQ` input. It generalises the single-line interrupt of the current top level to `NIRQ` channels. Each channel gets synchronisation, per-channel mask, level or edge capture, and fixed priority. A service handshake keeps `ExtIRQ` and the channel ID stable from presentation through end-of-interrupt.

## Interface
- `N`, 64: config data bus width; read data is zero-extended to `N`.
- `NIRQ`, 4: number of interrupt channels, legal range 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per channel, legal range 2..3.
- `IDW`, `$clog2(NIRQ)` (minimum 1): channel ID width; derived, not overridden.

Ports:
- `CLOCK_50` input 1: single clock. All state is updated on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `irq_in` input `NIRQ`: raw asynchronous interrupt lines, active-high.
- `cfg_we` input 1: config write strobe.
- `cfg_addr` input 2: config register select.
- `cfg_wdata` input `N`: write data; only the low `NIRQ` bits are used.
- `cfg_rdata` output `N`: combinational read of the register at `cfg_addr`.
- `irq_ack` input 1: one-cycle pulse from the core when it takes the exception.
- `irq_eoi` input 1: one-cycle pulse from the core at end of the handler (ERET).
- `ExtIRQ` output 1: interrupt request to the core.
- `irq_id` output `IDW`: ID of the presented or in-service channel.
- `irq_active` output 1: high while an interrupt is in service.

## Operation
- Register map:
  - addr 0 `MASK`: read/write; 1 = channel enabled.
  - addr 1 `MODE`: read/write; 1 = edge-triggered. Exists only under the macro in Configuration.
  - addr 2 `PEND`: read; write-1-to-clear for edge channels.
  - addr 3: reads 0; writes are ignored.
- Level channel: the `PEND` bit equals the synchronised input. Ack and W1C have no effect on it.
- Edge channel: the `PEND` bit is set on a 0→1 transition of the synchronised input. It is cleared by W1C, or by `irq_ack` when the channel equals `irq_id`. If a set and a clear land on the same edge, the set wins.
- Candidate set = `PEND & MASK`. Priority is fixed: the lowest index wins.
- FSM, three states:
  - IDLE: `ExtIRQ`=0, `irq_active`=0. Moves to ASSERT when the candidate set is non-zero; the winning ID is latched into `irq_id` on that same edge.
  - ASSERT: `ExtIRQ`=1 and `irq_id` is held stable.
    - `irq_ack` → SERVICE.
    - If the latched channel's candidate bit drops before ack (level source withdrawn, masked, or W1C'd) → IDLE, with `ExtIRQ` falling on that edge.
    - Ack and withdrawal on the same edge: ack wins.
  - SERVICE: `ExtIRQ`=0, `irq_active`=1, `irq_id` held. `irq_eoi` → IDLE. No nesting.
- `irq_ack` outside ASSERT and `irq_eoi` outside SERVICE are ignored.
- Config writes are legal in every state and take effect on the next edge.

## Timing
- Reset values: `MASK`=0, `MODE`=0, `PEND`=0, all synchroniser flops 0, FSM=IDLE, `ExtIRQ`=0, `irq_id`=0, `irq_active`=0, `cfg_rdata` reflects the reset registers.
- Input latency, with `SYNC_STAGES`=2: `irq_in` is first sampled high at edge k. `PEND` updates at edge k+2. ASSERT and `ExtIRQ`=1 take effect at edge k+3.
- All outputs except `cfg_rdata` are driven from registers only. There is no combinational path from `irq_in`, `irq_ack` or `irq_eoi` to any output.
- After `irq_eoi` at edge e, FSM=IDLE at e. If candidates remain, `ExtIRQ` re-asserts at e+1, so `ExtIRQ` is low for at least one full cycle between interrupts.
- `reset` asserted mid-service returns to IDLE immediately and drops `ExtIRQ` asynchronously. Pending edges are lost.

## Configuration
- `EXT_IRQ_EDGE_EN` defined: the `MODE` register and edge capture logic are built, and per-channel edge/level behaviour applies as described above.
- `EXT_IRQ_EDGE_EN` undefined:
  - All channels are level-sensitive.
  - addr 1 reads 0 and ignores writes.
  - W1C on `PEND` has no effect.
  - No edge-detect flops are synthesised.

## Structure
- Package `irq_pkg` holds:
  - the FSM state enum `irq_state_t` {IDLE, ASSERT, SERVICE};
  - register address constants `IRQ_ADDR_MASK`, `IRQ_ADDR_MODE`, `IRQ_ADDR_PEND`.
- Sub-module `irq_sync`, one instance per channel: a `SYNC_STAGES` synchroniser plus a registered previous-value flop that provides a `rise` pulse. The top generates `NIRQ` instances.

## Test plan
- Reset state: hold `reset`=0 with `irq_in`=4'b1111. Required: `ExtIRQ`=0, `irq_id`=0, `cfg_rdata`=0 at all addresses. After release with `MASK`=0, `ExtIRQ` stays 0.
- Level priority: write `MASK`=4'b1111, then drive `irq_in`=4'b1010. Required: `ExtIRQ`=1 three edges after sampling, `irq_id`=1. Ack → `irq_active`=1, `ExtIRQ`=0. Eoi with `irq_in` still 4'b1010 → re-assert with `irq_id`=1.
- Withdrawal: level channel 2 only. Deassert `irq_in[2]` while in ASSERT, before ack. Required: `ExtIRQ` returns to 0 and FSM returns to IDLE; a late `irq_ack` is ignored and `irq_active` stays 0.
- Edge capture (`EXT_IRQ_EDGE_EN`): `MODE`=4'b0001, `MASK`=4'b0001, 1-cycle pulse on `irq_in[0]`. Required: `PEND`=1 is held after the pulse ends. Ack clears `PEND[0]`. Eoi leaves `ExtIRQ`=0.
- Edge set/clear collision: a new edge on channel 0 arrives on the same edge as ack. Required: `PEND[0]`=1 remains, and `ExtIRQ` re-asserts one cycle after eoi.
- Reset mid-service: assert `reset`=0 while in SERVICE. Required: `irq_active`, `ExtIRQ` and `PEND` go to 0 immediately, without waiting for a clock edge.
